// File: rtl/vga_scanout_if.sv
// Framebuffer read port plus VGA DAC pins between the scanout block and its neighbours.
// The master side is the scanout engine; the slave side is the framebuffer and DAC.
interface vga_scanout_if #(
  parameter int FB_AW = 15
) ();
  logic [FB_AW-1:0] fb_addr;
  logic             fb_re;
  logic [7:0]       fb_rdata;
  logic             vga_clk;
  logic [7:0]       red_vga;
  logic [7:0]       green_vga;
  logic [7:0]       blue_vga;
  logic             h_sync;
  logic             v_sync;
  logic             blank_n;
  logic             sync_n;
  logic             vblank;

  modport master (
    output fb_addr, fb_re, vga_clk, red_vga, green_vga, blue_vga,
    output h_sync, v_sync, blank_n, sync_n, vblank,
    input  fb_rdata
  );

  modport slave (
    input  fb_addr, fb_re, vga_clk, red_vga, green_vga, blue_vga,
    input  h_sync, v_sync, blank_n, sync_n, vblank,
    output fb_rdata
  );
endinterface

// File: rtl/vga_scanout.sv
// VGA scanout: walks the raster at sysclk/DIV, reads an upscaled RGB332 framebuffer
// and drives registered DAC pins plus a one-clock vertical-blank pulse.
module vga_scanout #(
  parameter int DIV        = 4,
  parameter int H_VIS      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VIS      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SCALE_LOG2 = 2,
  parameter int FB_W       = 160,
  parameter int FB_AW      = 15
) (
  input  logic          clk,
  input  logic          reset,
  vga_scanout_if.master vga
);
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(DIV);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [DW-1:0]    div_cnt_r;
  logic [HW-1:0]    h_cnt_r;
  logic [VW-1:0]    v_cnt_r;
  logic [FB_AW-1:0] fb_addr_r;
  logic             fb_re_r;
  logic             vga_clk_r;
  logic [7:0]       red_r;
  logic [7:0]       green_r;
  logic [7:0]       blue_r;
  logic             h_sync_r;
  logic             v_sync_r;
  logic             blank_n_r;
  logic             vblank_r;

  logic [DW-1:0]    div_next_s;
  logic             pix_ce_s;
  logic             visible_s;
  logic             h_last_s;
  logic             v_last_s;
  logic             hs_act_s;
  logic             vs_act_s;
  logic             vblank_hit_s;
  logic [FB_AW-1:0] addr_s;
  logic [7:0]       red_s;
  logic [7:0]       green_s;
  logic [7:0]       blue_s;

  function automatic logic [7:0] expand3(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  function automatic logic [7:0] expand2(input logic [1:0] c);
    return {c, c, c, c};
  endfunction

  // Raster position decode, next divider value and framebuffer address.
  always_comb begin
    pix_ce_s   = (div_cnt_r == DW'(DIV - 1));
    if (pix_ce_s) begin
      div_next_s = {DW{1'b0}};
    end else begin
      div_next_s = div_cnt_r + DW'(1'b1);
    end
    visible_s    = (h_cnt_r < HW'(H_VIS)) && (v_cnt_r < VW'(V_VIS));
    h_last_s     = (h_cnt_r == HW'(H_TOTAL - 1));
    v_last_s     = (v_cnt_r == VW'(V_TOTAL - 1));
    hs_act_s     = (h_cnt_r >= HW'(H_VIS + H_FP)) && (h_cnt_r < HW'(H_VIS + H_FP + H_SYNC));
    vs_act_s     = (v_cnt_r >= VW'(V_VIS + V_FP)) && (v_cnt_r < VW'(V_VIS + V_FP + V_SYNC));
    vblank_hit_s = pix_ce_s && h_last_s && (v_cnt_r == VW'(V_VIS - 1));
    addr_s = FB_AW'((32'(v_cnt_r) >> SCALE_LOG2) * 32'(FB_W) + (32'(h_cnt_r) >> SCALE_LOG2));
  end

  // Colour expansion from RGB332; outside the visible area the pixel is forced black.
  always_comb begin
    red_s   = 8'h00;
    green_s = 8'h00;
    blue_s  = 8'h00;
    if (visible_s) begin
      red_s   = expand3(vga.fb_rdata[7:5]);
      green_s = expand3(vga.fb_rdata[4:2]);
      blue_s  = expand2(vga.fb_rdata[1:0]);
    end else begin
      red_s   = 8'h00;
      green_s = 8'h00;
      blue_s  = 8'h00;
    end
  end

  // Divider, raster counters, read port and pin registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_r <= {DW{1'b0}};
      h_cnt_r   <= {HW{1'b0}};
      v_cnt_r   <= {VW{1'b0}};
      fb_addr_r <= {FB_AW{1'b0}};
      fb_re_r   <= 1'b0;
      vga_clk_r <= 1'b0;
      red_r     <= 8'h00;
      green_r   <= 8'h00;
      blue_r    <= 8'h00;
      h_sync_r  <= 1'b1;
      v_sync_r  <= 1'b1;
      blank_n_r <= 1'b0;
      vblank_r  <= 1'b0;
    end else begin
      div_cnt_r <= div_next_s;
      fb_addr_r <= addr_s;
      fb_re_r   <= visible_s;
      // Computed from the next divider value so the DAC clock falls with the pixel update.
      vga_clk_r <= (div_next_s >= DW'(DIV / 2));
      vblank_r  <= vblank_hit_s;
      if (pix_ce_s) begin
        red_r     <= red_s;
        green_r   <= green_s;
        blue_r    <= blue_s;
        blank_n_r <= visible_s;
        h_sync_r  <= ~hs_act_s;
        v_sync_r  <= ~vs_act_s;
        if (h_last_s) begin
          h_cnt_r <= {HW{1'b0}};
          if (v_last_s) begin
            v_cnt_r <= {VW{1'b0}};
          end else begin
            v_cnt_r <= v_cnt_r + VW'(1'b1);
          end
        end else begin
          h_cnt_r <= h_cnt_r + HW'(1'b1);
        end
      end
    end
  end

  assign vga.fb_addr   = fb_addr_r;
  assign vga.fb_re     = fb_re_r;
  assign vga.vga_clk   = vga_clk_r;
  assign vga.red_vga   = red_r;
  assign vga.green_vga = green_r;
  assign vga.blue_vga  = blue_r;
  assign vga.h_sync    = h_sync_r;
  assign vga.v_sync    = v_sync_r;
  assign vga.blank_n   = blank_n_r;
  assign vga.sync_n    = 1'b1;
  assign vga.vblank    = vblank_r;
endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: one default-timing instance and one tiny-raster
// instance for whole-frame behaviour.
module tb_vga_scanout;
  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;
  logic rd_mode;
  logic [7:0] rd_const;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  vga_scanout_if #(.FB_AW(15)) if_a ();
  vga_scanout_if #(.FB_AW(8))  if_b ();

  vga_scanout dut_a (.clk(clk), .reset(reset_a), .vga(if_a));

  vga_scanout #(
    .H_VIS(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SCALE_LOG2(1), .FB_W(4), .FB_AW(8)
  ) dut_b (.clk(clk), .reset(reset_b), .vga(if_b));

  always #5 clk = ~clk;

  // Synchronous-read framebuffer models.
  always @(posedge clk) if_a.fb_rdata <= rd_mode ? if_a.fb_addr[7:0] : rd_const;
  always @(posedge clk) if_b.fb_rdata <= if_b.fb_addr;

  function automatic logic [7:0] px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return {r[7:5], g[7:5], b[7:6]};
  endfunction

  function automatic logic [45:0] pins_a();
    return {if_a.fb_addr, if_a.fb_re, if_a.vga_clk, if_a.red_vga, if_a.green_vga, if_a.blue_vga,
            if_a.h_sync, if_a.v_sync, if_a.blank_n, if_a.sync_n, if_a.vblank};
  endfunction

  localparam logic [45:0] RESET_PINS = {15'd0, 1'b0, 1'b0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic release_a(input logic mode, input logic [7:0] cval);
    @(negedge clk);
    rd_mode = mode;
    rd_const = cval;
    reset_a = 1'b1;
    @(negedge clk);
    reset_a = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rd_mode = 1'b0;
    rd_const = 8'hE3;
    reset_a = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (pins_a() !== RESET_PINS) begin
      n_bad++;
      $display("FAIL reset_pins: got %h expected %h", pins_a(), RESET_PINS);
    end
    reset_a = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_cmp++;
      if ({if_a.blank_n, if_a.vga_clk, if_a.fb_re, if_a.fb_addr} !==
          {(k >= 4), ((k % 4) >= 2), 1'b1, 15'd0}) begin
        n_bad++;
        $display("FAIL reset_release clk%0d: blank/vclk/re/addr got %b%b%b %0d expected %b%b1 0",
                 k, if_a.blank_n, if_a.vga_clk, if_a.fb_re, if_a.fb_addr, (k >= 4), ((k % 4) >= 2));
      end
    end
  endtask

  task automatic test_colour();
    release_a(1'b0, 8'hE3);
    run_to(4);
    n_cmp++;
    if ({if_a.red_vga, if_a.green_vga, if_a.blue_vga} !== 24'hFF00FF) begin
      n_bad++;
      $display("FAIL colour_E3: got %h expected ff00ff", {if_a.red_vga, if_a.green_vga, if_a.blue_vga});
    end
    rd_const = 8'h49;
    run_to(8);
    n_cmp++;
    if ({if_a.red_vga, if_a.green_vga, if_a.blue_vga} !== 24'h494955) begin
      n_bad++;
      $display("FAIL colour_49: got %h expected 494955", {if_a.red_vga, if_a.green_vga, if_a.blue_vga});
    end
    run_to(4 + 4 * 639);
    n_cmp++;
    if ({if_a.red_vga, if_a.green_vga, if_a.blue_vga, if_a.blank_n} !== {24'h494955, 1'b1}) begin
      n_bad++;
      $display("FAIL colour_h639: got %h/%b expected 494955/1",
               {if_a.red_vga, if_a.green_vga, if_a.blue_vga}, if_a.blank_n);
    end
    run_to(4 + 4 * 640);
    n_cmp++;
    if ({if_a.red_vga, if_a.green_vga, if_a.blue_vga, if_a.blank_n} !== {24'h000000, 1'b0}) begin
      n_bad++;
      $display("FAIL colour_h640: got %h/%b expected 000000/0",
               {if_a.red_vga, if_a.green_vga, if_a.blue_vga}, if_a.blank_n);
    end
  endtask

  task automatic test_addressing();
    int pix_n [9] = '{0, 1, 2, 3, 4, 639, 3200, 3204, 3839};
    int pix_a [9] = '{0, 0, 0, 0, 1, 159, 160, 161, 319};
    release_a(1'b1, 8'h00);
    for (int i = 0; i < 9; i++) begin
      run_to(4 + 4 * pix_n[i]);
      n_cmp++;
      if (px(if_a.red_vga, if_a.green_vga, if_a.blue_vga) !== 8'(pix_a[i])) begin
        n_bad++;
        $display("FAIL addressing pixel%0d: got %0d expected %0d", pix_n[i],
                 px(if_a.red_vga, if_a.green_vga, if_a.blue_vga), 8'(pix_a[i]));
      end
    end
  endtask

  task automatic test_sync();
    int first_low = -1;
    int low_cnt = 0;
    int blank_bad = 0;
    int vs_bad = 0;
    release_a(1'b0, 8'h55);
    for (int k = 1; k <= 3204; k++) begin
      tick();
      if (if_a.h_sync === 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = k;
      end
      if (if_a.blank_n !== ((k >= 4) && (k < 4 + 4 * 640) || (k >= 4 + 4 * 800))) blank_bad++;
      if (if_a.v_sync !== 1'b1) vs_bad++;
    end
    n_cmp++;
    if (first_low !== 4 + 656 * 4) begin
      n_bad++;
      $display("FAIL hsync_start: got clk %0d expected clk %0d", first_low, 4 + 656 * 4);
    end
    n_cmp++;
    if (low_cnt !== 384) begin
      n_bad++;
      $display("FAIL hsync_width: got %0d expected 384", low_cnt);
    end
    n_cmp++;
    if (blank_bad !== 0) begin
      n_bad++;
      $display("FAIL blank_line0: got %0d wrong clks expected 0", blank_bad);
    end
    n_cmp++;
    if (vs_bad !== 0) begin
      n_bad++;
      $display("FAIL vsync_line0: got %0d low clks expected 0", vs_bad);
    end
  endtask

  task automatic test_mid_reset();
    release_a(1'b1, 8'h00);
    run_to(4 + 4 * (5 * 800 + 100));
    n_cmp++;
    if (px(if_a.red_vga, if_a.green_vga, if_a.blue_vga) !== 8'd185) begin
      n_bad++;
      $display("FAIL midreset_before: got %0d expected 185", px(if_a.red_vga, if_a.green_vga, if_a.blue_vga));
    end
    reset_a = 1'b1;
    tick();
    n_cmp++;
    if (pins_a() !== RESET_PINS) begin
      n_bad++;
      $display("FAIL midreset_pins: got %h expected %h", pins_a(), RESET_PINS);
    end
    reset_a = 1'b0;
    cyc = 0;
    tick();
    n_cmp++;
    if ({if_a.fb_re, if_a.fb_addr} !== {1'b1, 15'd0}) begin
      n_bad++;
      $display("FAIL midreset_addr: got re %b addr %0d expected re 1 addr 0", if_a.fb_re, if_a.fb_addr);
    end
    run_to(4);
    n_cmp++;
    if ({if_a.blank_n, px(if_a.red_vga, if_a.green_vga, if_a.blue_vga)} !== {1'b1, 8'd0}) begin
      n_bad++;
      $display("FAIL midreset_first: got blank %b pix %0d expected 1 0",
               if_a.blank_n, px(if_a.red_vga, if_a.green_vga, if_a.blue_vga));
    end
    run_to(20);
    n_cmp++;
    if (px(if_a.red_vga, if_a.green_vga, if_a.blue_vga) !== 8'd1) begin
      n_bad++;
      $display("FAIL midreset_h4: got %0d expected 1", px(if_a.red_vga, if_a.green_vga, if_a.blue_vga));
    end
  endtask

  task automatic test_frame_wrap();
    int vb_cnt = 0;
    int vb_first = -1;
    int vb_last = -1;
    int vs_low = 0;
    @(negedge clk);
    reset_b = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 1100; k++) begin
      tick();
      if (if_b.vblank === 1'b1) begin
        vb_cnt++;
        if (vb_first < 0) vb_first = k;
        vb_last = k;
      end
      if (k <= 336 && if_b.v_sync === 1'b0) vs_low++;
      if (k >= 4 && ((k - 4) % 4) == 0 && (k - 4) / 4 < 168) begin
        int n;
        int h;
        int v;
        logic vis;
        logic [7:0] ea;
        n = (k - 4) / 4;
        h = n % 12;
        v = (n / 12) % 7;
        vis = (h < 8) && (v < 4);
        ea = vis ? 8'((v / 2) * 4 + h / 2) : 8'd0;
        n_cmp++;
        if ({px(if_b.red_vga, if_b.green_vga, if_b.blue_vga), if_b.blank_n, if_b.h_sync, if_b.v_sync} !==
            {ea, vis, !((h >= 9) && (h < 11)), (v != 5)}) begin
          n_bad++;
          $display("FAIL frame_pixel n%0d (h%0d v%0d): pix/blank/hs/vs got %0d/%b/%b/%b expected %0d/%b/%b/%b",
                   n, h, v, px(if_b.red_vga, if_b.green_vga, if_b.blue_vga), if_b.blank_n, if_b.h_sync,
                   if_b.v_sync, ea, vis, !((h >= 9) && (h < 11)), (v != 5));
        end
      end
    end
    n_cmp++;
    if (vb_cnt !== 3) begin
      n_bad++;
      $display("FAIL vblank_count: got %0d expected 3", vb_cnt);
    end
    n_cmp++;
    if (vb_first !== 192) begin
      n_bad++;
      $display("FAIL vblank_first: got clk %0d expected clk 192", vb_first);
    end
    n_cmp++;
    if (vb_last - vb_first !== 2 * 336) begin
      n_bad++;
      $display("FAIL vblank_period: got %0d expected %0d", vb_last - vb_first, 2 * 336);
    end
    n_cmp++;
    if (vs_low !== 48) begin
      n_bad++;
      $display("FAIL vsync_width: got %0d expected 48", vs_low);
    end
  endtask

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    rd_mode = 1'b0;
    rd_const = 8'h00;
    test_reset();
    test_colour();
    test_addressing();
    test_sync();
    test_mid_reset();
    test_frame_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
